uart_rx: RTL and testbench

UART receiver, the counterpart of the existing FIFO-fed transmitter. It samples the serial line at OVERSAMPLE_RATE x baud and deserialises start/data/parity/stop frames. Each received byte is pushed into a downstream write-side FIFO. It flags parity, framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity sense constants
// and the oversample tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_WRITE  = 3'd5
    } state_t;

    localparam logic EVEN_PAR = 1'b0;
    localparam logic ODD_PAR  = 1'b1;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
        int div;
        div = clk_hz / (baud * os);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks. restart_i
// holds the divider at zero so the first tick after release is phase aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE_RATE);
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (restart_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver feeding a write-side FIFO. Define UART_RX_MAJORITY_VOTE_EN to
// decide each bit by a 2-of-3 vote over neighbouring ticks instead of one sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE_RATE = 16,
    parameter int NUM_DATA_BITS   = 8,
    parameter int PARITY_ON       = 1,
    parameter int PARITY_EO       = 1,
    parameter int NUM_STOP_BITS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [NUM_DATA_BITS-1:0] fifo_wr_data_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_err_o,
    output logic                     busy_o
);

    localparam int OS_W  = $clog2(OVERSAMPLE_RATE);
    localparam int IDX_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
    localparam logic [OS_W-1:0]  MID_LAST = OS_W'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [OS_W-1:0]  BIT_LAST = OS_W'(OVERSAMPLE_RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);
    localparam logic             PAR_SENSE = (PARITY_EO != 0) ? ODD_PAR : EVEN_PAR;

    state_t state_q, state_d;

    logic                     sync1_q, sync2_q, hist_q;
    logic [OS_W-1:0]          s_cnt_q;
    logic [IDX_W-1:0]         bit_idx_q;
    logic [NUM_DATA_BITS-1:0] shreg_q;
    logic [NUM_DATA_BITS-1:0] data_q;
    logic                     par_err_q;
    logic                     stop_cnt_q;
    logic                     frame_err_q;

    logic tick, restart, mid_hit, bit_hit, sample_bit, exp_par;
    logic cnt_clr, frame_clr, shift_en, par_load, stop_rpt, frame_err_d;

    uart_baud_tick #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .BAUD_RATE       (BAUD_RATE),
        .OVERSAMPLE_RATE (OVERSAMPLE_RATE)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (restart),
        .tick_o    (tick)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two previous tick samples; the vote closes on the decision tick itself.
    logic [1:0] vote_q;
    assign sample_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & sync2_q) | (vote_q[0] & sync2_q);
`else
    assign sample_bit = sync2_q;
`endif

    assign mid_hit = tick && (s_cnt_q == MID_LAST);
    assign bit_hit = tick && (s_cnt_q == BIT_LAST);
    assign exp_par = (^shreg_q) ^ PAR_SENSE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        cnt_clr     = 1'b0;
        frame_clr   = 1'b0;
        shift_en    = 1'b0;
        par_load    = 1'b0;
        stop_rpt    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                restart   = 1'b1;
                cnt_clr   = 1'b1;
                frame_clr = 1'b1;
                if (hist_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (mid_hit) begin
                    cnt_clr = 1'b1;
                    state_d = sample_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_hit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = (PARITY_ON != 0) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (bit_hit) begin
                    cnt_clr  = 1'b1;
                    par_load = 1'b1;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_hit) begin
                    cnt_clr = 1'b1;
                    if (!sample_bit) begin
                        frame_err_d = 1'b1;
                        state_d     = RX_IDLE;
                    end else if ((NUM_STOP_BITS == 2) && !stop_cnt_q) begin
                        stop_rpt = 1'b1;
                    end else begin
                        state_d = RX_WRITE;
                    end
                end
            end
            RX_WRITE: begin
                state_d = RX_IDLE;
            end
            default: begin
                restart   = 1'b1;
                cnt_clr   = 1'b1;
                frame_clr = 1'b1;
                state_d   = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            s_cnt_q     <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            stop_cnt_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q      <= 2'b11;
`endif
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (tick) begin
                vote_q <= {vote_q[0], sync2_q};
            end
`endif
            if (cnt_clr) begin
                s_cnt_q <= '0;
            end else if (tick) begin
                s_cnt_q <= s_cnt_q + 1'b1;
            end
            if (frame_clr) begin
                bit_idx_q  <= '0;
                par_err_q  <= 1'b0;
                stop_cnt_q <= 1'b0;
            end else begin
                if (shift_en) begin
                    bit_idx_q <= bit_idx_q + 1'b1;
                end
                if (par_load) begin
                    par_err_q <= sample_bit ^ exp_par;
                end
                if (stop_rpt) begin
                    stop_cnt_q <= 1'b1;
                end
            end
            // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
            if (shift_en) begin
                shreg_q <= {sample_bit, shreg_q[NUM_DATA_BITS-1:1]};
            end
            if (fifo_wr_en_o) begin
                data_q <= shreg_q;
            end
        end
    end

    // Write handshake: fifo_wr_en_o is a one-cycle strobe that only fires while
    // fifo_full_i is low; a full FIFO drops the byte and raises overrun_err_o.
    assign fifo_wr_en_o   = (state_q == RX_WRITE) && !fifo_full_i;
    assign overrun_err_o  = (state_q == RX_WRITE) && fifo_full_i;
    assign parity_err_o   = fifo_wr_en_o && par_err_q;
    assign fifo_wr_data_o = fifo_wr_en_o ? shreg_q : data_q;
    assign frame_err_o    = frame_err_q;
    assign busy_o         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk per bit, odd parity, one stop bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       fifo_full_i = 1'b0;
    logic       fifo_wr_en_o;
    logic [7:0] fifo_wr_data_o;
    logic       parity_err_o, frame_err_o, overrun_err_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_wr = 0, n_par = 0, n_par_wr = 0, n_frame = 0, n_ovr = 0;
    int wr_cyc = 0;
    logic [7:0] last_data = '0;
    int s_wr, s_par, s_par_wr, s_frame, s_ovr;
    int t0;

    uart_rx #(
        .CLK_FREQ_HZ     (1_600_000),
        .BAUD_RATE       (100_000),
        .OVERSAMPLE_RATE (16),
        .NUM_DATA_BITS   (8),
        .PARITY_ON       (1),
        .PARITY_EO       (1),
        .NUM_STOP_BITS   (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_err_o  (overrun_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (fifo_wr_en_o) begin
                n_wr++;
                last_data = fifo_wr_data_o;
                wr_cyc = cyc;
                if (parity_err_o) n_par_wr++;
            end
            if (parity_err_o)  n_par++;
            if (frame_err_o)   n_frame++;
            if (overrun_err_o) n_ovr++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_wr = n_wr; s_par = n_par; s_par_wr = n_par_wr; s_frame = n_frame; s_ovr = n_ovr;
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx_i = b;
        repeat (15) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        @(posedge clk);
        #1 rx_i = 1'b0;
        t0 = cyc;
        repeat (15) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(par);
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    initial begin
        bit busy_seen;
        bit busy_dropped;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    busy_o, 0);
        check("rst_wr_en",   fifo_wr_en_o, 0);
        check("rst_data",    fifo_wr_data_o, 8'h00);
        check("rst_par",     parity_err_o, 0);
        check("rst_frame",   frame_err_o, 0);
        check("rst_overrun", overrun_err_o, 0);
        #1 rst_i = 1'b0;
        repeat (20) @(posedge clk);

        // 0xA5: four ones, odd parity bit 1
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5_wr",      n_wr - s_wr, 1);
        check("a5_data",    last_data, 8'hA5);
        check("a5_latency", wr_cyc - t0, 171);
        check("a5_par",     n_par - s_par, 0);
        check("a5_frame",   n_frame - s_frame, 0);
        check("a5_overrun", n_ovr - s_ovr, 0);

        // 0x3C: four ones, odd parity wants 1; send 0
        snap();
        send_frame(8'h3C, 1'b0, 1'b1);
        check("3c_wr",     n_wr - s_wr, 1);
        check("3c_data",   last_data, 8'h3C);
        check("3c_par_wr", n_par_wr - s_par_wr, 1);
        check("3c_par",    n_par - s_par, 1);

        // 0x55 with stop bit low, then 0x0F clean
        snap();
        send_frame(8'h55, 1'b1, 1'b0);
        check("55_frame", n_frame - s_frame, 1);
        check("55_wr",    n_wr - s_wr, 0);
        snap();
        send_frame(8'h0F, 1'b1, 1'b1);
        check("0f_wr",    n_wr - s_wr, 1);
        check("0f_data",  last_data, 8'h0F);
        check("0f_frame", n_frame - s_frame, 0);

        // 4-clk glitch low
        snap();
        busy_seen = 0;
        busy_dropped = 0;
        @(posedge clk);
        #1 rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o) busy_seen = 1;
            else if (busy_seen) begin
                busy_dropped = 1;
                break;
            end
        end
        repeat (30) @(posedge clk);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_drop", busy_dropped, 1);
        check("glitch_wr",        n_wr - s_wr, 0);
        check("glitch_frame",     n_frame - s_frame, 0);
        check("glitch_par",       n_par - s_par, 0);

        // 0x81 into a full FIFO
        snap();
        fifo_full_i = 1'b1;
        send_frame(8'h81, 1'b1, 1'b1);
        @(negedge clk);
        check("81_overrun",   n_ovr - s_ovr, 1);
        check("81_wr",        n_wr - s_wr, 0);
        check("81_par",       n_par - s_par, 0);
        check("81_frame",     n_frame - s_frame, 0);
        check("81_data_hold", fifo_wr_data_o, 8'h0F);
        fifo_full_i = 1'b0;

        // reset during data bit 3 of 0xFF
        snap();
        @(posedge clk);
        #1 rx_i = 1'b0;
        repeat (15) @(posedge clk);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("ff_busy_pre", busy_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check("ff_rst_busy",  busy_o, 0);
        check("ff_rst_wr",    fifo_wr_en_o, 0);
        check("ff_rst_data",  fifo_wr_data_o, 8'h00);
        check("ff_rst_frame", frame_err_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (200) @(posedge clk);
        check("ff_no_write", n_wr - s_wr, 0);
        check("ff_no_frame", n_frame - s_frame, 0);
        snap();
        send_frame(8'h12, 1'b1, 1'b1);
        check("12_wr",   n_wr - s_wr, 1);
        check("12_data", last_data, 8'h12);
        check("12_par",  n_par - s_par, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
